rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   N-input round-robin arbitrating multiplexer with valid/ready handshake and a
//   single registered output stage. It is the sequential front end of the mux
//   datapath: it computes the select internally, exports it as grant_idx, and
//   forwards the winning beat downstream. Fairness: no input starves while
//   out_ready keeps toggling.
// PARAMETERS
//   N_IN   4   number of input channels, 2..16
//   W      8   data width per channel in bits
//   IDX_W  $clog2(N_IN)  derived, not overridable; width of grant_idx/pointer
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous assert, active-low reset
//   in_valid   in   N_IN      per-channel valid
//   in_data    in   N_IN*W    channel i at bits [i*W +: W]
//   in_ready   out  N_IN      per-channel ready, one-hot or zero (combinational)
//   out_valid  out  1         output register holds a beat
//   out_data   out  W         registered winning data
//   out_ready  in   1         downstream accepts out_data
//   grant_idx  out  IDX_W     channel index of the beat in out_data (registered)
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, out_data=0, grant_idx=0, ptr=0.
//     in_ready=0 while rst_n=0. An in-flight output beat is discarded, not
//     replayed. Deassertion is synchronised externally.
//   Output stage states:
//     EMPTY: out_valid=0.
//     FULL: out_valid=1.
//     load_en = !out_valid | out_ready.
//   Arbitration (combinational):
//     Scan channels ptr, ptr+1, ..., ptr+N_IN-1 mod N_IN.
//     win = first channel with in_valid=1; any_req = |in_valid.
//   Handshake:
//     in_ready[win]=load_en & any_req; all other in_ready bits are 0.
//     A transfer occurs on a rising edge where in_valid[i] & in_ready[i].
//   On an input transfer:
//     out_data<=in_data[win], grant_idx<=win, out_valid<=1.
//     ptr<=(win+1) mod N_IN.
//   Output transfer without a new input (out_valid & out_ready & !any_req):
//     out_valid<=0.
//     out_data and grant_idx hold their last value.
//   Simultaneous output and input transfer in the same cycle: the register
//     reloads with the new beat, out_valid stays 1, and there is no bubble.
//     Sustained throughput is one beat per clock.
//   Backpressure: FULL with out_ready=0 gives all in_ready=0. out_data,
//     grant_idx and out_valid hold stable.
//   Latency: input transfer at edge k gives out_valid=1 with that data after
//     edge k, i.e. 1 cycle.
//   ptr wraps from N_IN-1 to 0. ptr changes only on an input transfer.
//   An idle or blocked cycle does not move ptr.
//   Upstream rule: once in_valid[i]=1 it stays 1 with stable data until
//     transferred. Violations are not detected.
//   No combinational path from in_valid/in_data to out_valid/out_data.
//   The only comb path is in_valid/out_ready -> in_ready.
// TESTING
//   1 Reset: rst_n=0 asserted mid-beat with out_valid=1 -> out_valid=0
//     immediately (async); out_data=0, grant_idx=0, in_ready=0.
//   2 Single requester: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 ->
//     one cycle later out_valid=1, out_data=A5, grant_idx=2; ptr=3.
//   3 Round-robin fairness: all four in_valid held with data 8'h10..8'h13 and
//     out_ready=1 -> grant_idx sequence 0,1,2,3,0 on consecutive cycles,
//     out_valid stays 1 throughout.
//   4 Backpressure: FULL with out_ready=0 for 5 cycles -> in_ready=0 and
//     out_data/grant_idx stable; out_ready=1 -> next beat loaded the same
//     cycle, no bubble.
//   5 Wrap: ptr=3 and in_valid=4'b1001 -> grant 3, then grant 0, then grant 3.
//   6 Drain: single beat with in_valid dropping to 0 after transfer and
//     out_ready=1 -> out_valid 1 for exactly one cycle, then 0.
//     out_data holds its last value.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: valid/ready bundle between upstream channels, the arbiter and the downstream sink
interface rr_arb_mux_if #(
    parameter int N_IN = 4,
    parameter int W    = 8
);
    localparam int IDX_W = $clog2(N_IN);
    logic [N_IN-1:0]   in_valid;
    logic [N_IN*W-1:0] in_data;
    logic [N_IN-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_ready;
    logic [IDX_W-1:0]  grant_idx;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, grant_idx
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, grant_idx
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbitrating mux with one registered output stage
module rr_arb_mux #(
    parameter int N_IN = 4,
    parameter int W    = 8
) (
    input logic          clk,
    input logic          rst_n,
    rr_arb_mux_if.slave  bus
);
    localparam int IDX_W = $clog2(N_IN);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr, win;
    logic [IDX_W:0]   pos;
    logic             any_req, load_en, xfer_in;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            ptr           <= '0;
            bus.out_data  <= '0;
            bus.grant_idx <= '0;
        end else begin
            state <= state_nx;
            if (xfer_in) begin
                bus.out_data  <= bus.in_data[win*W +: W];
                bus.grant_idx <= win;
                ptr           <= (win == IDX_W'(N_IN-1)) ? '0 : win + 1'b1;
            end
        end
    end
    // first requester at or after ptr, scanning modulo N_IN
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_IN; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            pos = (pos >= (IDX_W+1)'(N_IN)) ? pos - (IDX_W+1)'(N_IN) : pos;
            if (!any_req && bus.in_valid[pos[IDX_W-1:0]]) begin
                any_req = 1'b1;
                win     = pos[IDX_W-1:0];
            end
        end
    end
    always_comb begin
        state_nx = xfer_in ? FULL : (state == FULL && bus.out_ready) ? EMPTY : state;
    end
    always_comb begin
        bus.out_valid = (state == FULL);
        load_en       = !bus.out_valid || bus.out_ready;
        xfer_in       = rst_n && load_en && any_req;
        bus.in_ready  = xfer_in ? {{(N_IN-1){1'b0}}, 1'b1} << win : '0;
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of arbitration order, handshake, backpressure and reset
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    rr_arb_mux_if #(.N_IN(4), .W(8)) bus ();
    rr_arb_mux #(.N_IN(4), .W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] g);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_grant"}, 32'(bus.grant_idx), 32'(g));
    endtask
    initial begin
        bus.in_valid  = 4'b0000;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk_out("rst0", 1'b0, 8'h00, 2'd0);
        chk("rst0_ready", 32'(bus.in_ready), 32'h0);
        step();
        rst_n = 1'b1;
        // single requester on channel 2
        bus.in_valid  = 4'b0100;
        bus.in_data   = 32'h00A5_0000;
        bus.out_ready = 1'b1;
        #1;
        chk("single_ready", 32'(bus.in_ready), 32'h4);
        step();
        chk_out("single", 1'b1, 8'hA5, 2'd2);
        // drain: one beat out, then empty with data held
        bus.in_valid = 4'b0000;
        #1;
        chk("drain_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk_out("drain", 1'b0, 8'hA5, 2'd2);
        step();
        chk_out("drain_idle", 1'b0, 8'hA5, 2'd2);
        // wrap: ptr is 3 after granting channel 2
        bus.in_valid = 4'b1001;
        bus.in_data  = 32'h2300_0020;
        step();
        chk_out("wrap1", 1'b1, 8'h23, 2'd3);
        step();
        chk_out("wrap2", 1'b1, 8'h20, 2'd0);
        step();
        chk_out("wrap3", 1'b1, 8'h23, 2'd3);
        // fairness: ptr back at 0, all channels requesting
        bus.in_valid = 4'b1111;
        bus.in_data  = 32'h1312_1110;
        step();
        chk_out("rr0", 1'b1, 8'h10, 2'd0);
        step();
        chk_out("rr1", 1'b1, 8'h11, 2'd1);
        step();
        chk_out("rr2", 1'b1, 8'h12, 2'd2);
        step();
        chk_out("rr3", 1'b1, 8'h13, 2'd3);
        step();
        chk_out("rr4", 1'b1, 8'h10, 2'd0);
        // backpressure holds everything
        bus.out_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("bp", 1'b1, 8'h10, 2'd0);
            chk("bp_ready_hold", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'h2);
        step();
        chk_out("bp_release", 1'b1, 8'h11, 2'd1);
        // async reset mid-beat
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
        chk("rst_mid_ready", 32'(bus.in_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk_out("post_rst", 1'b1, 8'h10, 2'd0);
        bus.in_valid = 4'b0000;
        step();
        chk_out("final_drain", 1'b0, 8'h10, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
